pwm_deadtime_inserter: RTL and testbench

Converts the single-ended PWM waveform from the PWM generator into a complementary high-side/low-side gate-drive pair. A programmable dead band, with both outputs low, is inserted at every transition. A latched fault input forces both outputs off. Sits directly downstream of the PWM generator and drives the power-stage gate drivers.

---
 rtl/pwm_deadtime_inserter_if.sv | 25 ++
 rtl/pwm_deadtime_inserter.sv | 86 ++++++++
 tb/tb_pwm_deadtime_inserter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadtime_inserter_if.sv
// Bundles the dead-time inserter's PWM input, control inputs and gate-drive outputs.
// The master modport is the driving side; the slave modport is the inserter itself.
interface pwm_deadtime_inserter_if #(
  parameter int unsigned DT_WIDTH = 8
);
  logic                pwm_in;
  logic                enable;
  logic [DT_WIDTH-1:0] dead_time;
  logic                fault_in;
  logic                fault_clr;
  logic                out_hi;
  logic                out_lo;
  logic                dt_active;
  logic                fault_flag;

  modport master (
    output pwm_in, enable, dead_time, fault_in, fault_clr,
    input  out_hi, out_lo, dt_active, fault_flag
  );

  modport slave (
    input  pwm_in, enable, dead_time, fault_in, fault_clr,
    output out_hi, out_lo, dt_active, fault_flag
  );
endinterface

// File: rtl/pwm_deadtime_inserter.sv
// Splits a single-ended PWM into a complementary high/low gate-drive pair.
// A programmable dead band is inserted at each transition, and a latched fault forces both sides off.
module pwm_deadtime_inserter #(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pwm_deadtime_inserter_if.slave bus
);
  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] IDLE    = 3'd0;
  localparam logic [ST_W-1:0] LO_ON   = 3'd1;
  localparam logic [ST_W-1:0] DT_RISE = 3'd2;
  localparam logic [ST_W-1:0] HI_ON   = 3'd3;
  localparam logic [ST_W-1:0] DT_FALL = 3'd4;
  localparam logic [ST_W-1:0] FAULT   = 3'd5;

  logic [ST_W-1:0]     state;
  logic [ST_W-1:0]     state_nxt;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] cnt_nxt;
  logic [DT_WIDTH-1:0] cnt_load;

  // A dead time of 0 behaves as 1, so the band is always at least one cycle long.
  assign cnt_load = (bus.dead_time == '0) ? '0 : DT_WIDTH'(bus.dead_time - DT_WIDTH'(1));

  // Next state: fault first, then enable, then normal PWM following.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.fault_in) begin
      state_nxt = FAULT;
    end else if (state == FAULT) begin
      if (bus.fault_clr) state_nxt = IDLE;
    end else if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = bus.pwm_in ? HI_ON : LO_ON;
        LO_ON: begin
          if (bus.pwm_in) begin
            state_nxt = DT_RISE;
            cnt_nxt   = cnt_load;
          end
        end
        HI_ON: begin
          if (!bus.pwm_in) begin
            state_nxt = DT_FALL;
            cnt_nxt   = cnt_load;
          end
        end
        DT_RISE: begin
          if (!bus.pwm_in)     state_nxt = LO_ON;
          else if (cnt == '0)  state_nxt = HI_ON;
          else                 cnt_nxt   = cnt - DT_WIDTH'(1);
        end
        DT_FALL: begin
          if (bus.pwm_in)      state_nxt = HI_ON;
          else if (cnt == '0)  state_nxt = LO_ON;
          else                 cnt_nxt   = cnt - DT_WIDTH'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered decodes of the next state, so they always match the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.out_hi     <= 1'b0;
      bus.out_lo     <= 1'b0;
      bus.dt_active  <= 1'b0;
      bus.fault_flag <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bus.out_hi     <= (state_nxt == HI_ON);
      bus.out_lo     <= (state_nxt == LO_ON);
      bus.dt_active  <= (state_nxt == DT_RISE) || (state_nxt == DT_FALL);
      bus.fault_flag <= (state_nxt == FAULT);
    end
  end
endmodule

// File: tb/tb_pwm_deadtime_inserter.sv
// Self-checking bench for pwm_deadtime_inserter.
// Directed scenarios with literal expectations, then random stimulus, all checked every cycle against a behavioural model.
module tb_pwm_deadtime_inserter;
  logic clk;
  logic rst;

  pwm_deadtime_inserter_if #(.DT_WIDTH(8)) bus ();

  pwm_deadtime_inserter #(.DT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which side is driven, whether a band is pending, and how many
  // more cycles the new PWM level must persist before the opposite side may turn on.
  int m_side;   // 0 none, 1 low side, 2 high side
  bit m_band;
  bit m_to_hi;
  int m_rem;
  bit m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_side = 0; m_band = 0; m_fault = 0; m_rem = 0; m_to_hi = 0;
    end else if (bus.fault_in) begin
      m_fault = 1; m_side = 0; m_band = 0;
    end else if (m_fault) begin
      if (bus.fault_clr) m_fault = 0;
    end else if (!bus.enable) begin
      m_side = 0; m_band = 0;
    end else if (m_band) begin
      if (bus.pwm_in == m_to_hi) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_band = 0;
          m_side = m_to_hi ? 2 : 1;
        end
      end else begin
        m_band = 0;
        m_side = m_to_hi ? 1 : 2;
      end
    end else if (m_side == 0) begin
      m_side = bus.pwm_in ? 2 : 1;
    end else if ((m_side == 2) != bus.pwm_in) begin
      m_band  = 1;
      m_to_hi = bus.pwm_in;
      m_rem   = (bus.dead_time == 0) ? 1 : int'(bus.dead_time);
      m_side  = 0;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    chk("out_hi", int'(bus.out_hi), int'(m_side == 2));
    chk("out_lo", int'(bus.out_lo), int'(m_side == 1));
    chk("dt_active", int'(bus.dt_active), int'(m_band));
    chk("fault_flag", int'(bus.fault_flag), int'(m_fault));
    chk("no_overlap", int'(bus.out_hi && bus.out_lo), 0);
  end

  task automatic drive(input bit p, input bit e, input int dt, input bit f, input bit fc);
    bus.pwm_in    = p;
    bus.enable    = e;
    bus.dead_time = 8'(dt);
    bus.fault_in  = f;
    bus.fault_clr = fc;
  endtask

  // Counts both-off cycles until the wanted side turns on, bounded by a cycle budget.
  task automatic wait_side(input bit want_hi, output int lows);
    bit done;
    done = 0;
    lows = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (want_hi ? bus.out_hi : bus.out_lo) done = 1;
      else if (!bus.out_hi && !bus.out_lo) lows++;
    end
    chk(want_hi ? "reach_hi" : "reach_lo", int'(done), 1);
  endtask

  initial begin
    int lows, lows0, n_hi, n_lo, n_off, n_dt, hi_seen, run_left;
    bit p;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_out_hi", int'(bus.out_hi), 0);
    chk("rst_out_lo", int'(bus.out_lo), 0);
    chk("rst_dt_active", int'(bus.dt_active), 0);
    chk("rst_fault_flag", int'(bus.fault_flag), 0);
    rst = 1'b0;

    // 20-cycle period, 50% duty, dead time 4: per period 6 high, 6 low, 8 both off.
    n_hi = 0; n_lo = 0; n_off = 0; n_dt = 0;
    for (int per = 0; per < 3; per++) begin
      for (int i = 0; i < 20; i++) begin
        drive(i < 10, 1, 4, 0, 0);
        @(negedge clk);
        if (per == 2) begin
          n_hi  += int'(bus.out_hi);
          n_lo  += int'(bus.out_lo);
          n_off += int'(!bus.out_hi && !bus.out_lo);
          n_dt  += int'(bus.dt_active);
        end
      end
    end
    chk("period_hi_cycles", n_hi, 6);
    chk("period_lo_cycles", n_lo, 6);
    chk("period_off_cycles", n_off, 8);
    chk("period_dt_cycles", n_dt, 8);

    // Dead time 0 acts as a single-cycle band.
    drive(0, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    drive(1, 1, 0, 0, 0);
    wait_side(1, lows);
    chk("dt0_band", lows, 1);

    // A 3-cycle high pulse under dead time 8 is swallowed.
    drive(0, 1, 8, 0, 0);
    repeat (12) @(negedge clk);
    hi_seen = 0;
    drive(1, 1, 8, 0, 0);
    repeat (3) begin @(negedge clk); hi_seen += int'(bus.out_hi); end
    drive(0, 1, 8, 0, 0);
    repeat (12) begin @(negedge clk); hi_seen += int'(bus.out_hi); end
    chk("short_pulse_hi", hi_seen, 0);
    chk("short_pulse_lo_back", int'(bus.out_lo), 1);

    // Dead time sampled at band entry: 10, then the next band uses 2.
    drive(1, 1, 10, 0, 0);
    @(negedge clk);
    lows0 = int'(!bus.out_hi && !bus.out_lo);
    bus.dead_time = 8'd2;
    wait_side(1, lows);
    chk("dt10_band", lows + lows0, 10);
    repeat (4) @(negedge clk);
    drive(0, 1, 2, 0, 0);
    wait_side(0, lows);
    chk("dt2_band", lows, 2);

    // Fault latch, ignored clear while fault is high, then release.
    drive(1, 1, 2, 0, 0);
    repeat (6) @(negedge clk);
    chk("pre_fault_hi", int'(bus.out_hi), 1);
    drive(1, 1, 2, 1, 0);
    @(negedge clk);
    chk("fault_hi_off", int'(bus.out_hi), 0);
    chk("fault_flag_set", int'(bus.fault_flag), 1);
    drive(1, 1, 2, 0, 0);
    @(negedge clk);
    chk("fault_held", int'(bus.fault_flag), 1);
    drive(1, 1, 2, 1, 1);
    @(negedge clk);
    chk("fault_clr_blocked", int'(bus.fault_flag), 1);
    drive(1, 1, 2, 0, 1);
    @(negedge clk);
    chk("fault_cleared", int'(bus.fault_flag), 0);
    chk("idle_hi_off", int'(bus.out_hi), 0);
    chk("idle_lo_off", int'(bus.out_lo), 0);
    drive(1, 1, 2, 0, 0);
    @(negedge clk);
    chk("resume_hi", int'(bus.out_hi), 1);

    // Asynchronous reset between clock edges while the high side is on.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_hi", int'(bus.out_hi), 0);
    @(negedge clk);
    bus.pwm_in = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_lo", int'(bus.out_lo), 1);
    chk("post_rst_hi", int'(bus.out_hi), 0);

    // Random stimulus; the per-cycle compare process does the checking.
    p = 0;
    run_left = 0;
    for (int c = 0; c < 10000; c++) begin
      if (run_left == 0) begin
        p = ~p;
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      bus.pwm_in    = p;
      bus.enable    = ($urandom_range(0, 99) != 0);
      bus.fault_in  = ($urandom_range(0, 299) == 0);
      bus.fault_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) bus.dead_time = 8'($urandom_range(0, 6));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
